// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, buffer entry type and jump-target helper for
// the instruction-fetch stage.
//   NOP_INSTR        - instruction presented to decode when nothing is valid
//   RESET_PC_DEFAULT - default reset program counter
//   PC_INC           - sequential PC step (one 32-bit word)
//   fetch_entry_t    - one fetch-buffer slot {pc, instr}
//   jump_target()    - J-type target formed from the jump's PC and instr_index
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Upper nibble comes from the jump's sequential successor, not the jump itself.
    function automatic logic [31:0] jump_target(input logic [31:0] last_pc,
                                                input logic [25:0] instr_index);
        logic [31:0] seq_pc;
        seq_pc = last_pc + PC_INC;
        return {seq_pc[31:28], instr_index, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus.
//   IMemReq     - fetch request valid (master -> slave)
//   IMemAddr    - word-aligned fetch address (master -> slave)
//   IMemGnt     - request accepted this cycle (slave -> master)
//   IMemRdValid - response data valid (slave -> master)
//   IMemRdData  - response instruction (slave -> master)
interface fetch_unit_if;

    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemGnt;
    logic        IMemRdValid;
    logic [31:0] IMemRdData;

    modport master (
        output IMemReq, IMemAddr,
        input  IMemGnt, IMemRdValid, IMemRdData
    );

    modport slave (
        input  IMemReq, IMemAddr,
        output IMemGnt, IMemRdValid, IMemRdData
    );

endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of {pc, instr} between memory and decode.
//   clk, reset_n - clock, async active-low reset
//   push_i       - write wdata_i at the tail
//   pop_i        - drop the head entry
//   clear_i      - empty the FIFO; wins over push and pop
//   wdata_i      - entry to write
//   head_o       - current head entry (valid when !empty_o)
//   empty_o      - no entries
//   full_o       - both entries occupied
//   count_o      - occupancy 0..2
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         clear_i,
    input  fetch_entry_t wdata_i,
    output fetch_entry_t head_o,
    output logic         empty_o,
    output logic         full_o,
    output logic [1:0]   count_o
);

    fetch_entry_t mem_q [2];
    logic         wptr_q, wptr_d;
    logic         rptr_q, rptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign count_o = count_q;
    assign head_o  = mem_q[rptr_q];

    // A push into a full buffer only lands if the head leaves the same cycle.
    assign do_push = push_i & ~clear_i & (~full_o | pop_i);
    assign do_pop  = pop_i  & ~clear_i & ~empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear_i) begin
            wptr_d  = 1'b0;
            rptr_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            count_d = count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (do_push) mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, issues one word fetch at a
// time to instruction memory, buffers returned instructions in fetch_buffer and
// applies jump (ID) / taken-branch (EX) redirects, squashing wrong-path work.
//   clk, reset_n   - clock, async active-low reset
//   AnyStall       - decode holding; head is not consumed
//   Jump_ID        - jump in ID, JumpTgt_ID is its instr_index
//   BranchTaken_EX - taken branch in EX, BranchTgt_EX is its byte target
//   imem           - instruction-memory bus (master side)
//   FetchData_IF   - instruction to decode (NOP when not valid)
//   FetchPc_IF     - PC of FetchData_IF (0 when not valid)
//   FetchValid_IF  - FetchData_IF is a real instruction
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                AnyStall,
    input  logic                Jump_ID,
    input  logic [25:0]         JumpTgt_ID,
    input  logic                BranchTaken_EX,
    input  logic [31:0]         BranchTgt_EX,
    fetch_unit_if.master        imem,
    output logic [31:0]         FetchData_IF,
    output logic [31:0]         FetchPc_IF,
    output logic                FetchValid_IF
);

    localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);

    logic [31:0]  pc_q, pc_d;
    logic [31:0]  reqpc_q, reqpc_d;     // PC of the request in flight
    logic [31:0]  lastpc_q, lastpc_d;   // PC of the last instruction handed to decode
    logic         inflight_q, inflight_d;
    logic         squash_q, squash_d;
    logic         started_q;            // holds IMemReq low until the first edge after reset

    fetch_entry_t buf_head, buf_wdata;
    logic         buf_empty, buf_full;
    logic [1:0]   buf_count;
    logic         buf_push, buf_pop;

    logic         redirect, rsp, grant, outstanding, pop_req;
    logic [31:0]  redir_tgt;
    logic [2:0]   occ;

    assign redirect  = BranchTaken_EX | Jump_ID;
    // Branch is the older instruction, so it overrides a jump behind it.
    assign redir_tgt = BranchTaken_EX ? BranchTgt_EX : jump_target(lastpc_q, JumpTgt_ID);

    assign rsp         = imem.IMemRdValid & inflight_q;
    // A response returning this cycle frees the single outstanding slot, which
    // lets the next request go out back-to-back with a 1-cycle memory.
    assign outstanding = inflight_q & ~imem.IMemRdValid;
    assign pop_req     = FetchValid_IF & ~AnyStall;
    // Occupancy after this edge: the returning response still counts as a slot.
    assign occ         = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop_req};

    assign imem.IMemReq  = started_q & ~outstanding & (occ < DEPTH);
    assign imem.IMemAddr = pc_q;
    assign grant         = imem.IMemReq & imem.IMemGnt;

    // Redirect discards both sides of the buffer traffic for this cycle.
    assign buf_pop   = pop_req & ~redirect;
    assign buf_push  = rsp & ~squash_q & ~redirect & (~buf_full | buf_pop);
    assign buf_wdata = '{pc: reqpc_q, instr: imem.IMemRdData};

    fetch_buffer u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (buf_push),
        .pop_i   (buf_pop),
        .clear_i (redirect),
        .wdata_i (buf_wdata),
        .head_o  (buf_head),
        .empty_o (buf_empty),
        .full_o  (buf_full),
        .count_o (buf_count)
    );

    assign FetchValid_IF = ~buf_empty;
    assign FetchData_IF  = buf_empty ? NOP_INSTR : buf_head.instr;
    assign FetchPc_IF    = buf_empty ? 32'h0 : buf_head.pc;

    always_comb begin
        pc_d       = pc_q;
        reqpc_d    = reqpc_q;
        lastpc_d   = lastpc_q;
        inflight_d = inflight_q;
        squash_d   = squash_q;
        if (rsp) begin
            inflight_d = 1'b0;
            squash_d   = 1'b0;
        end
        if (grant) begin
            inflight_d = 1'b1;
            reqpc_d    = pc_q;
            pc_d       = pc_q + PC_INC;
        end
        if (buf_pop) lastpc_d = buf_head.pc;
        if (redirect) begin
            pc_d     = redir_tgt;
            // Anything still in flight past this edge is wrong-path; a response
            // landing this cycle is simply dropped and needs no squash.
            squash_d = outstanding | grant;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            reqpc_q    <= RESET_PC;
            lastpc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            squash_q   <= 1'b0;
            started_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            reqpc_q    <= reqpc_d;
            lastpc_q   <= lastpc_d;
            inflight_q <= inflight_d;
            squash_q   <= squash_d;
            started_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit. A small memory
// model answers each granted request after 'lat' cycles with ~addr as data.
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        AnyStall;
    logic        Jump_ID;
    logic [25:0] JumpTgt_ID;
    logic        BranchTaken_EX;
    logic [31:0] BranchTgt_EX;
    logic [31:0] FetchData_IF;
    logic [31:0] FetchPc_IF;
    logic        FetchValid_IF;

    fetch_unit_if imem ();

    int   n_checks = 0;
    int   n_fail   = 0;
    int   lat      = 1;
    logic gnt_en   = 1'b1;

    logic        pend;
    int          cnt;
    logic [31:0] paddr;

    assign imem.IMemGnt = gnt_en;

    fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .AnyStall       (AnyStall),
        .Jump_ID        (Jump_ID),
        .JumpTgt_ID     (JumpTgt_ID),
        .BranchTaken_EX (BranchTaken_EX),
        .BranchTgt_EX   (BranchTgt_EX),
        .imem           (imem),
        .FetchData_IF   (FetchData_IF),
        .FetchPc_IF     (FetchPc_IF),
        .FetchValid_IF  (FetchValid_IF)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: drops everything pending while reset is asserted.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            imem.IMemRdValid <= 1'b0;
            imem.IMemRdData  <= 32'h0;
            pend  <= 1'b0;
            cnt   <= 0;
            paddr <= 32'h0;
        end else begin
            imem.IMemRdValid <= 1'b0;
            if (pend) begin
                if (cnt == 1) begin
                    imem.IMemRdValid <= 1'b1;
                    imem.IMemRdData  <= ~paddr;
                    pend <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (imem.IMemReq && imem.IMemGnt) begin
                if (lat == 1) begin
                    imem.IMemRdValid <= 1'b1;
                    imem.IMemRdData  <= ~imem.IMemAddr;
                end else begin
                    pend  <= 1'b1;
                    cnt   <= lat - 1;
                    paddr <= imem.IMemAddr;
                end
            end
        end
    end

    task automatic wait_req(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (imem.IMemReq) begin ok = 1'b1; return; end
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (FetchValid_IF) begin ok = 1'b1; return; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        AnyStall = 0; Jump_ID = 0; JumpTgt_ID = '0; BranchTaken_EX = 0; BranchTgt_EX = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (imem.IMemReq !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem.IMemReq); end
        n_checks++; if (FetchValid_IF !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", FetchValid_IF); end
        n_checks++; if (FetchData_IF !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", FetchData_IF); end
        n_checks++; if (FetchPc_IF !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", FetchPc_IF); end
    endtask

    // Ends at the negedge where head = 28, request = 36 outstanding-free.
    task automatic test_sequential();
        logic [31:0] e;
        reset_n = 1'b1;
        #1;
        n_checks++; if (imem.IMemReq !== 1'b0) begin n_fail++; $display("FAIL release_req: got %b want 0", imem.IMemReq); end
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            e = 32'(4 * k);
            n_checks++; if (imem.IMemReq !== 1'b1 || imem.IMemAddr !== e) begin
                n_fail++; $display("FAIL seq_req k=%0d: got req=%b addr=%h want req=1 addr=%h", k, imem.IMemReq, imem.IMemAddr, e);
            end
            if (k == 1) begin
                n_checks++; if (FetchValid_IF !== 1'b0) begin n_fail++; $display("FAIL seq_early_valid: got %b want 0", FetchValid_IF); end
            end
            if (k >= 2) begin
                e = 32'(4 * (k - 2));
                n_checks++; if (FetchValid_IF !== 1'b1 || FetchPc_IF !== e || FetchData_IF !== ~e) begin
                    n_fail++; $display("FAIL seq_out k=%0d: got v=%b pc=%h d=%h want v=1 pc=%h d=%h", k, FetchValid_IF, FetchPc_IF, FetchData_IF, e, ~e);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] e;
        AnyStall = 1'b1;
        #1;
        n_checks++; if (imem.IMemReq !== 1'b0) begin n_fail++; $display("FAIL stall_req0: got %b want 0", imem.IMemReq); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (FetchValid_IF !== 1'b1 || FetchPc_IF !== 32'd28 || FetchData_IF !== ~32'd28 || imem.IMemReq !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold i=%0d: got v=%b pc=%h d=%h req=%b want v=1 pc=1c d=%h req=0", i, FetchValid_IF, FetchPc_IF, FetchData_IF, imem.IMemReq, ~32'd28);
            end
        end
        AnyStall = 1'b0;
        #1;
        n_checks++; if (imem.IMemReq !== 1'b1 || imem.IMemAddr !== 32'd36) begin
            n_fail++; $display("FAIL stall_resume_req: got req=%b addr=%h want req=1 addr=24", imem.IMemReq, imem.IMemAddr);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            e = 32'(28 + 4 * i);
            n_checks++; if (FetchValid_IF !== 1'b1 || FetchPc_IF !== e || FetchData_IF !== ~e) begin
                n_fail++; $display("FAIL stall_resume i=%0d: got v=%b pc=%h want v=1 pc=%h", i, FetchValid_IF, FetchPc_IF, e);
            end
        end
    endtask

    task automatic test_jump();
        bit ok;
        @(negedge clk); BranchTaken_EX = 1'b1; BranchTgt_EX = 32'h1000_0010;
        @(negedge clk); BranchTaken_EX = 1'b0;
        wait_valid(30, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL jump_pre_timeout: got no valid want valid"); end
        else if (FetchPc_IF !== 32'h1000_0010) begin n_fail++; $display("FAIL jump_pre_pc: got %h want 10000010", FetchPc_IF); end
        // That head pops on the next edge, so LastPc = 0x1000_0010 for the jump.
        @(negedge clk); Jump_ID = 1'b1; JumpTgt_ID = 26'h000_0040;
        @(negedge clk); Jump_ID = 1'b0;
        #1;
        n_checks++; if (FetchValid_IF !== 1'b0) begin n_fail++; $display("FAIL jump_flush: got %b want 0", FetchValid_IF); end
        wait_req(20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL jump_req_timeout: got no req want req"); end
        else if (imem.IMemAddr !== 32'h1000_0100) begin n_fail++; $display("FAIL jump_addr: got %h want 10000100", imem.IMemAddr); end
        wait_valid(30, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL jump_valid_timeout: got no valid want valid"); end
        else if (FetchPc_IF !== 32'h1000_0100 || FetchData_IF !== ~32'h1000_0100) begin
            n_fail++; $display("FAIL jump_out: got pc=%h d=%h want pc=10000100 d=%h", FetchPc_IF, FetchData_IF, ~32'h1000_0100);
        end
    endtask

    task automatic test_branch_squash();
        bit ok;
        bit seen;
        int viol;
        lat = 4;
        wait_req(20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL sq_req_timeout: got no req want req"); end
        @(negedge clk);
        @(negedge clk); BranchTaken_EX = 1'b1; BranchTgt_EX = 32'h0000_0200;
        @(negedge clk); BranchTaken_EX = 1'b0;
        seen = 1'b0; viol = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (imem.IMemRdValid) seen = 1'b1;
            else begin
                if (imem.IMemReq) viol++;
                @(negedge clk);
            end
        end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL sq_rsp_timeout: got no response want response"); end
        n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL sq_early_req: got %0d early requests want 0", viol); end
        wait_req(20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL sq_req2_timeout: got no req want req"); end
        else if (imem.IMemAddr !== 32'h200) begin n_fail++; $display("FAIL sq_addr: got %h want 200", imem.IMemAddr); end
        wait_valid(40, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL sq_valid_timeout: got no valid want valid"); end
        else if (FetchPc_IF !== 32'h200 || FetchData_IF !== ~32'h200) begin
            n_fail++; $display("FAIL sq_out: got pc=%h d=%h want pc=200 d=%h", FetchPc_IF, FetchData_IF, ~32'h200);
        end
    endtask

    // Leaves the pipeline at the first 0x300 head: response 0x304 landing, request 0x308 up.
    task automatic test_priority();
        bit ok;
        lat = 1;
        @(negedge clk);
        BranchTaken_EX = 1'b1; BranchTgt_EX = 32'h0000_0300;
        Jump_ID = 1'b1; JumpTgt_ID = 26'h000_0055;
        @(negedge clk); BranchTaken_EX = 1'b0; Jump_ID = 1'b0;
        wait_req(30, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL prio_req_timeout: got no req want req"); end
        else if (imem.IMemAddr !== 32'h300) begin n_fail++; $display("FAIL prio_addr: got %h want 300", imem.IMemAddr); end
        wait_valid(30, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL prio_valid_timeout: got no valid want valid"); end
        else if (FetchPc_IF !== 32'h300) begin n_fail++; $display("FAIL prio_pc: got %h want 300", FetchPc_IF); end
    endtask

    task automatic test_grant_hold();
        bit ok;
        gnt_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (imem.IMemReq !== 1'b1 || imem.IMemAddr !== 32'h308) begin
                n_fail++; $display("FAIL hold_req i=%0d: got req=%b addr=%h want req=1 addr=308", i, imem.IMemReq, imem.IMemAddr);
            end
        end
        gnt_en = 1'b1;
        wait_valid(20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL hold_valid_timeout: got no valid want valid"); end
        else if (FetchPc_IF !== 32'h308) begin n_fail++; $display("FAIL hold_pc: got %h want 308", FetchPc_IF); end
    endtask

    task automatic test_wrap();
        bit ok;
        @(negedge clk); BranchTaken_EX = 1'b1; BranchTgt_EX = 32'hFFFF_FFF8;
        @(negedge clk); BranchTaken_EX = 1'b0;
        wait_valid(30, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_timeout: got no valid want valid"); end
        else if (FetchPc_IF !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_pc0: got %h want fffffff8", FetchPc_IF); end
        @(negedge clk);
        n_checks++; if (FetchValid_IF !== 1'b1 || FetchPc_IF !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc1: got v=%b pc=%h want v=1 pc=fffffffc", FetchValid_IF, FetchPc_IF); end
        @(negedge clk);
        n_checks++; if (FetchValid_IF !== 1'b1 || FetchPc_IF !== 32'h0 || FetchData_IF !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL wrap_pc2: got v=%b pc=%h d=%h want v=1 pc=0 d=ffffffff", FetchValid_IF, FetchPc_IF, FetchData_IF);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        @(negedge clk); AnyStall = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++; if (FetchValid_IF !== 1'b1 || imem.IMemReq !== 1'b0) begin
            n_fail++; $display("FAIL rm_full: got v=%b req=%b want v=1 req=0", FetchValid_IF, imem.IMemReq);
        end
        reset_n = 1'b0;
        #1;
        n_checks++; if (FetchValid_IF !== 1'b0 || imem.IMemReq !== 1'b0 || FetchData_IF !== 32'h0 || FetchPc_IF !== 32'h0) begin
            n_fail++; $display("FAIL rm_async: got v=%b req=%b d=%h pc=%h want 0 0 0 0", FetchValid_IF, imem.IMemReq, FetchData_IF, FetchPc_IF);
        end
        @(negedge clk); AnyStall = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        #1;
        n_checks++; if (imem.IMemReq !== 1'b0) begin n_fail++; $display("FAIL rm_release_req: got %b want 0", imem.IMemReq); end
        @(negedge clk);
        n_checks++; if (imem.IMemReq !== 1'b1 || imem.IMemAddr !== 32'h0) begin
            n_fail++; $display("FAIL rm_restart: got req=%b addr=%h want req=1 addr=0", imem.IMemReq, imem.IMemAddr);
        end
        wait_valid(10, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rm_valid_timeout: got no valid want valid"); end
        else if (FetchPc_IF !== 32'h0 || FetchData_IF !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL rm_out: got pc=%h d=%h want pc=0 d=ffffffff", FetchPc_IF, FetchData_IF);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_jump();
        test_branch_squash();
        test_priority();
        test_grant_hold();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
